// File: rtl/wmst_tile_sched_pkg.sv
// Shared types and constants for the tile write-master scheduler.
package wmst_tile_sched_pkg;

    localparam int BEAT_BYTES = 16;
    localparam int ALIGN_LOG2 = 4;
    localparam int ROW_W_DEF  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0]          base;
        logic [31:0]          row_bytes;
        logic [ROW_W_DEF-1:0] rows;
        logic [31:0]          stride;
    } tile_cmd_t;

    function automatic logic misaligned(input logic [31:0] v, input int lg);
        return (v & ((32'd1 << lg) - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/wmst_tile_sched_if.sv
// Tile command handshake plus write-master control port.
interface wmst_tile_sched_if #(
    parameter int ROW_W = 16
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_base;
    logic [31:0]      cmd_row_bytes;
    logic [ROW_W-1:0] cmd_rows;
    logic [31:0]      cmd_stride;
    logic             wm_go;
    logic [31:0]      wm_base;
    logic [31:0]      wm_length;
    logic             wm_fixed_location;
    logic             wm_done;

    modport master (
        input  cmd_valid, cmd_base, cmd_row_bytes, cmd_rows, cmd_stride, wm_done,
        output cmd_ready, wm_go, wm_base, wm_length, wm_fixed_location
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_row_bytes, cmd_rows, cmd_stride, wm_done,
        input  cmd_ready, wm_go, wm_base, wm_length, wm_fixed_location
    );
endinterface

// File: rtl/wmst_tile_sched_addr_gen.sv
// Row counter and row-start address accumulator for one tile.
module wmst_addr_gen
    import wmst_tile_sched_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      base,
    input  logic [ROW_W-1:0] rows,
    input  logic [31:0]      stride,
    output logic [31:0]      addr,
    output logic [ROW_W-1:0] rows_left
);
    logic [31:0] stride_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            rows_left <= '0;
            stride_q  <= '0;
        end else if (load) begin
            addr      <= base;
            rows_left <= rows;
            stride_q  <= stride;
        end else if (step) begin
            // address wraps modulo 2^32 by design
            addr      <= addr + stride_q;
            rows_left <= rows_left - 1'b1;
        end
    end
endmodule

// File: rtl/wmst_tile_sched.sv
// Issues one write-master go per tile row and drains between rows.
//   state   | meaning
//   S_IDLE  | waiting for a tile command (cmd_ready=1)
//   S_ISSUE | wm_go high for one cycle with row base/length
//   S_ACK   | write master drops done; wm_done ignored
//   S_WAIT  | waiting for wm_done of the current row
//   S_DRAIN | DRAIN_CYC idle cycles so the last beat retires
//   S_DONE  | tile_done pulse
module wmst_tile_sched
    import wmst_tile_sched_pkg::*;
#(
    parameter int ROW_W      = ROW_W_DEF,
    parameter int DRAIN_CYC  = 2,
    parameter int ALIGN_LOG2 = wmst_tile_sched_pkg::ALIGN_LOG2
) (
    input  logic               clk,
    input  logic               rst,
    wmst_tile_sched_if.master  bus,
    output logic               busy,
    output logic               tile_done,
    output logic               cmd_err,
    output logic [ROW_W-1:0]   rows_left
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t      state, state_nxt;
    tile_cmd_t   cmd_in;
    logic [31:0] row_bytes_q;
    logic [31:0] cur_addr;
    logic [DW-1:0] drain_cnt;
    logic accept, bad, degen, load, step, drain_last;

    always_comb begin
        cmd_in.base      = bus.cmd_base;
        cmd_in.row_bytes = bus.cmd_row_bytes;
        cmd_in.rows      = bus.cmd_rows;
        cmd_in.stride    = bus.cmd_stride;
    end

    assign accept     = bus.cmd_valid && bus.cmd_ready && (state == S_IDLE);
    assign bad        = misaligned(cmd_in.base, ALIGN_LOG2) ||
                        misaligned(cmd_in.row_bytes, ALIGN_LOG2) ||
                        misaligned(cmd_in.stride, ALIGN_LOG2);
    assign degen      = (cmd_in.rows == '0) || (cmd_in.row_bytes == 32'd0);
    assign load       = accept && !bad && !degen;
    assign step       = (state == S_WAIT) && bus.wm_done;
    assign drain_last = (drain_cnt == '0);
    assign bus.wm_fixed_location = 1'b0;

    wmst_addr_gen #(.ROW_W(ROW_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .base      (cmd_in.base),
        .rows      (cmd_in.rows),
        .stride    (cmd_in.stride),
        .addr      (cur_addr),
        .rows_left (rows_left)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_ACK;
            S_ACK:   state_nxt = S_WAIT;
            S_WAIT:  if (bus.wm_done) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_last) state_nxt = (rows_left != '0) ? S_ISSUE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b0;
            tile_done     <= 1'b0;
            cmd_err       <= 1'b0;
            bus.wm_go     <= 1'b0;
            bus.wm_base   <= '0;
            bus.wm_length <= '0;
            row_bytes_q   <= '0;
            drain_cnt     <= '0;
        end else begin
            bus.cmd_ready <= (state_nxt == S_IDLE) && !accept;
            busy          <= (state_nxt != S_IDLE);
            tile_done     <= (state_nxt == S_DONE) || (accept && !bad && degen);
            cmd_err       <= accept && bad;
            bus.wm_go     <= (state_nxt == S_ISSUE);
            if (load) begin
                row_bytes_q   <= cmd_in.row_bytes;
                bus.wm_base   <= cmd_in.base;
                bus.wm_length <= cmd_in.row_bytes;
            end else if (state_nxt == S_ISSUE) begin
                bus.wm_base   <= cur_addr;
                bus.wm_length <= row_bytes_q;
            end
            if (state_nxt == S_DRAIN && state != S_DRAIN)
                drain_cnt <= DW'(DRAIN_CYC - 1);
            else if (state == S_DRAIN && !drain_last)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_wmst_tile_sched.sv
// Scoreboard bench for wmst_tile_sched with a model write master.
module tb_wmst_tile_sched;
    localparam int DRAIN_CYC = 2;

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        logic [31:0] rl;
    } go_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy, tile_done, cmd_err;
    logic [15:0] rows_left;
    bit          stall;
    int          mcnt;

    int n_tests = 0;
    int n_fail  = 0;

    go_exp_t go_q[$];
    int      done_q[$];
    int      err_q[$];
    int      cyc = 0, acc_cyc = 0, done_cyc = 0, go_count = 0;
    bit      acc_pending = 0;
    logic    done_prev = 1'b1;

    wmst_tile_sched_if #(.ROW_W(16)) bus ();

    wmst_tile_sched #(.ROW_W(16), .DRAIN_CYC(DRAIN_CYC), .ALIGN_LOG2(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .tile_done (tile_done),
        .cmd_err   (cmd_err),
        .rows_left (rows_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Model write master: done drops after go, rises 5 cycles after go unless stalled.
    always @(posedge clk) begin
        if (rst) begin
            bus.wm_done <= 1'b1;
            mcnt        <= 0;
        end else if (bus.wm_go) begin
            bus.wm_done <= 1'b0;
            mcnt        <= 4;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1 && !stall) begin
            bus.wm_done <= 1'b1;
            mcnt        <= 0;
        end
    end

    always @(negedge clk) begin
        go_exp_t e;
        int      k;
        cyc++;
        if (rst) begin
            done_prev   = bus.wm_done;
            acc_pending = 0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cyc     = cyc;
                acc_pending = 1;
            end
            if (bus.wm_done && !done_prev) done_cyc = cyc;
            done_prev = bus.wm_done;
            if (bus.wm_go) begin
                go_count++;
                if (go_q.size() == 0) begin
                    check("unexpected_go", 32'(bus.wm_go), 32'd0);
                end else begin
                    e = go_q.pop_front();
                    check("go_base", bus.wm_base, e.base);
                    check("go_length", bus.wm_length, e.len);
                    check("go_rows_left", 32'(rows_left), e.rl);
                    check("go_fixed_loc", 32'(bus.wm_fixed_location), 32'd0);
                    if (acc_pending) begin
                        check("go_lat_cmd", 32'(cyc - acc_cyc), 32'd1);
                        acc_pending = 0;
                    end else begin
                        check("go_lat_drain", 32'(cyc - done_cyc), 32'(DRAIN_CYC + 1));
                    end
                end
            end
            if (tile_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_tile_done", 32'(tile_done), 32'd0);
                end else begin
                    k = done_q.pop_front();
                    if (k == 1) begin
                        check("degen_done_lat", 32'(cyc - acc_cyc), 32'd1);
                        check("degen_busy", 32'(busy), 32'd0);
                        acc_pending = 0;
                    end else begin
                        check("tile_done_lat", 32'(cyc - done_cyc), 32'(DRAIN_CYC + 1));
                        check("tile_done_rows_left", 32'(rows_left), 32'd0);
                    end
                end
            end
            if (cmd_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_cmd_err", 32'(cmd_err), 32'd0);
                end else begin
                    k = err_q.pop_front();
                    check("err_lat", 32'(cyc - acc_cyc), 32'(k));
                    check("err_ready_low", 32'(bus.cmd_ready), 32'd0);
                    acc_pending = 0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] base, input logic [31:0] rb,
                        input logic [15:0] rows, input logic [31:0] stride);
        logic [31:0] a;
        for (int i = 0; i < 3000 && !bus.cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!bus.cmd_ready) begin
            check("ready_timeout", 32'(bus.cmd_ready), 32'd1);
            return;
        end
        bus.cmd_valid     = 1'b1;
        bus.cmd_base      = base;
        bus.cmd_row_bytes = rb;
        bus.cmd_rows      = rows;
        bus.cmd_stride    = stride;
        if (((base | rb | stride) & 32'hF) != 32'd0) begin
            err_q.push_back(1);
        end else if (rows == 16'd0 || rb == 32'd0) begin
            done_q.push_back(1);
        end else begin
            a = base;
            for (int i = 0; i < int'(rows); i++) begin
                go_q.push_back('{base: a, len: rb, rl: 32'(rows) - 32'(i)});
                a = a + stride;
            end
            done_q.push_back(0);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int pend;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && go_q.size() == 0 && done_q.size() == 0 && err_q.size() == 0) break;
            @(posedge clk); #1;
        end
        pend = go_q.size() + done_q.size() + err_q.size() + int'(busy);
        check(tag, 32'(pend), 32'd0);
    endtask

    initial begin
        int g0;
        rst               = 1'b1;
        stall             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_base      = '0;
        bus.cmd_row_bytes = '0;
        bus.cmd_rows      = '0;
        bus.cmd_stride    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tile_done", 32'(tile_done), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_rows_left", 32'(rows_left), 32'd0);
        check("rst_wm_go", 32'(bus.wm_go), 32'd0);
        check("rst_wm_base", bus.wm_base, 32'd0);
        check("rst_wm_length", bus.wm_length, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // Three-row tile
        g0 = go_count;
        send(32'h1000, 32'd64, 16'd3, 32'h200);
        wait_idle("tile3_complete");
        check("tile3_go_count", 32'(go_count - g0), 32'd3);

        // Misaligned row_bytes
        g0 = go_count;
        send(32'h2000, 32'd72, 16'd1, 32'h100);
        check("err_pulse", 32'(cmd_err), 32'd1);
        @(posedge clk); #1;
        check("err_ready_back", 32'(bus.cmd_ready), 32'd1);
        check("err_clear", 32'(cmd_err), 32'd0);
        check("err_no_go", 32'(go_count - g0), 32'd0);

        // Degenerate rows=0
        g0 = go_count;
        send(32'h0, 32'd16, 16'd0, 32'h10);
        check("degen_done", 32'(tile_done), 32'd1);
        check("degen_busy0", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("degen_busy1", 32'(busy), 32'd0);
        check("degen_no_go", 32'(go_count - g0), 32'd0);
        wait_idle("degen_idle");

        // Address wrap
        send(32'hFFFF_FF00, 32'd16, 16'd2, 32'h100);
        wait_idle("wrap_complete");

        // Stalled done on row 1, with a competing command
        stall = 1'b1;
        g0 = go_count;
        send(32'h3000, 32'd32, 16'd2, 32'h40);
        repeat (980) @(posedge clk);
        #1;
        bus.cmd_valid     = 1'b1;
        bus.cmd_base      = 32'h7000;
        bus.cmd_row_bytes = 32'd16;
        bus.cmd_rows      = 16'd1;
        bus.cmd_stride    = 32'h10;
        g0 = g0 + 0;
        begin
            int rdy_seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (bus.cmd_ready) rdy_seen++;
            end
            check("stall_ready_seen", 32'(rdy_seen), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_one_go", 32'(go_count - g0), 32'd1);
        check("stall_rows_left", 32'(rows_left), 32'd2);
        stall = 1'b0;
        wait_idle("stall_complete");
        check("stall_go_total", 32'(go_count - g0), 32'd2);

        // Reset during drain of row 2 of a 4-row tile
        g0 = go_count;
        send(32'h4000, 32'd16, 16'd4, 32'h20);
        for (int i = 0; i < 200 && go_count < g0 + 2; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 200 && !bus.wm_done; i++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_done_seen", 32'(bus.wm_done), 32'd1);
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        go_q.delete();
        done_q.delete();
        err_q.delete();
        @(posedge clk); #1;
        check("mid_rst_wm_go", 32'(bus.wm_go), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rows_left", 32'(rows_left), 32'd0);
        check("mid_rst_tile_done", 32'(tile_done), 32'd0);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_done", 32'(tile_done), 32'd0);
        end
        g0 = go_count;
        send(32'h5000, 32'd32, 16'd2, 32'h40);
        wait_idle("post_rst_tile");
        check("post_rst_go_count", 32'(go_count - g0), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
